// File: rtl/vdp_pkg.sv
// Shared video-pipeline types and constants used by the line-buffer producers.
package vdp_pkg;

   typedef logic [8:0]  colour_t;
   typedef logic [11:0] pix_x_t;
   typedef logic [8:0]  word_addr_t;
   typedef logic [7:0]  pix_mask_t;

   localparam int PIX_PER_WORD    = 8;
   localparam int MAX_LINE_PIXELS = 4096;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } span_state_e;

endpackage

// File: rtl/span_mask.sv
// Per-pixel enable mask for one 8-pixel word, given a half-open pixel range [x_px, end_px).
module span_mask
   import vdp_pkg::*;
(
   input  word_addr_t  word,
   input  logic [12:0] x_px,
   input  logic [12:0] end_px,
   output pix_mask_t   mask
);

   // Lane i covers pixel word*8+i; enable it when that pixel lies inside the range.
   always_comb begin
      mask = 8'h00;
      for (int i = 0; i < PIX_PER_WORD; i++) begin
         mask[i] = ({1'b0, word, 3'(i)} >= x_px) && ({1'b0, word, 3'(i)} < end_px);
      end
   end

endmodule

// File: rtl/span_writer.sv
// Draw-domain producer: span commands become masked 8-pixel word writes on the off-screen
// port, and an independent sweep clears the on-screen buffer to the background colour.
module span_writer
   import vdp_pkg::*;
#(
   parameter int      LINE_PIXELS = 640,
   parameter colour_t BG_COLOUR   = 9'h000
) (
   input  logic        clk_draw,
   input  logic        rst_draw_n,
   input  logic        span_valid,
   output logic        span_ready,
   input  logic [11:0] span_x,
   input  logic [12:0] span_len,
   input  logic [8:0]  span_colour,
   output logic [8:0]  addr_off_draw,
   output logic [7:0]  we_off_draw,
   output logic [71:0] colour_off_draw,
   input  logic        clear_start,
   output logic [8:0]  addr_on_draw,
   output logic        we_on_draw,
   output logic [71:0] colour_on_draw,
   output logic        busy,
   output logic        clear_busy
);

   localparam int          LINE_WORDS      = LINE_PIXELS / PIX_PER_WORD;
   localparam logic [12:0] LINE_END        = 13'(LINE_PIXELS);
   localparam word_addr_t  LAST_CLEAR_WORD = word_addr_t'(LINE_WORDS - 1);

   span_state_e state_r, state_s;
   word_addr_t  cur_word_r, cur_word_s;
   word_addr_t  last_word_r, last_word_s;
   logic [12:0] x_r, x_s;
   logic [12:0] end_r, end_s;
   colour_t     colour_r, colour_s;
   logic        span_ready_r, ready_s;
   logic        busy_r;
   word_addr_t  addr_off_r;
   pix_mask_t   we_off_r;
   logic [71:0] colour_off_r;
   logic        clear_busy_r, we_on_r;
   word_addr_t  clear_addr_r;

   logic [12:0] sum_s, clip_end_s, end_m1_s;
   logic        accept_s, live_s, issue_s;
   pix_mask_t   mask_s;

   // Clip the incoming span; 13-bit sum cannot wrap since x <= 4095 and len <= 4096.
   always_comb begin
      sum_s      = {1'b0, span_x} + span_len;
      clip_end_s = (sum_s > LINE_END) ? LINE_END : sum_s;
      end_m1_s   = clip_end_s - 13'd1;
      accept_s   = span_valid && span_ready_r;
      live_s     = clip_end_s > {1'b0, span_x};
   end

   // Span engine next state: a live accept loads a new span, otherwise step or fall idle.
   always_comb begin
      state_s     = state_r;
      cur_word_s  = cur_word_r;
      last_word_s = last_word_r;
      x_s         = x_r;
      end_s       = end_r;
      colour_s    = colour_r;
      issue_s     = 1'b0;
      if (accept_s && live_s) begin
         state_s     = ST_WRITE;
         cur_word_s  = span_x[11:3];
         last_word_s = 9'(end_m1_s >> 3);
         x_s         = {1'b0, span_x};
         end_s       = clip_end_s;
         colour_s    = span_colour;
         issue_s     = 1'b1;
      end else if (state_r == ST_WRITE && cur_word_r != last_word_r) begin
         cur_word_s = cur_word_r + 9'd1;
         issue_s    = 1'b1;
      end else begin
         state_s = ST_IDLE;
      end
      ready_s = (state_s == ST_IDLE) || (cur_word_s == last_word_s);
   end

   span_mask u_span_mask (
      .word   (cur_word_s),
      .x_px   (x_s),
      .end_px (end_s),
      .mask   (mask_s)
   );

   // Span engine state and registered off-screen write port.
   always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) begin
         state_r      <= ST_IDLE;
         cur_word_r   <= 9'd0;
         last_word_r  <= 9'd0;
         x_r          <= 13'd0;
         end_r        <= 13'd0;
         colour_r     <= 9'd0;
         span_ready_r <= 1'b1;
         busy_r       <= 1'b0;
         addr_off_r   <= 9'd0;
         we_off_r     <= 8'h00;
         colour_off_r <= 72'd0;
      end else begin
         state_r      <= state_s;
         cur_word_r   <= cur_word_s;
         last_word_r  <= last_word_s;
         x_r          <= x_s;
         end_r        <= end_s;
         colour_r     <= colour_s;
         span_ready_r <= ready_s;
         busy_r       <= (state_s == ST_WRITE);
         if (issue_s) begin
            addr_off_r   <= cur_word_s;
            we_off_r     <= mask_s;
            colour_off_r <= {8{colour_s}};
         end else begin
            we_off_r <= 8'h00;
         end
      end
   end

   // Clear sweep; a new start pulse always restarts from word 0.
   always_ff @(posedge clk_draw or negedge rst_draw_n) begin
      if (!rst_draw_n) begin
         clear_busy_r <= 1'b0;
         clear_addr_r <= 9'd0;
         we_on_r      <= 1'b0;
      end else if (clear_start) begin
         clear_busy_r <= 1'b1;
         clear_addr_r <= 9'd0;
         we_on_r      <= 1'b1;
      end else if (clear_busy_r && clear_addr_r != LAST_CLEAR_WORD) begin
         clear_addr_r <= clear_addr_r + 9'd1;
         we_on_r      <= 1'b1;
      end else begin
         clear_busy_r <= 1'b0;
         we_on_r      <= 1'b0;
      end
   end

   assign span_ready      = span_ready_r;
   assign busy            = busy_r;
   assign addr_off_draw   = addr_off_r;
   assign we_off_draw     = we_off_r;
   assign colour_off_draw = colour_off_r;
   assign addr_on_draw    = clear_addr_r;
   assign we_on_draw      = we_on_r;
   assign colour_on_draw  = {8{BG_COLOUR}};
   assign clear_busy      = clear_busy_r;

endmodule

// File: tb/tb_span_writer.sv
// Scoreboard bench for span_writer: expected words are queued at span acceptance and
// compared (address, mask, colour, cycle) as the DUT emits them.
module tb_span_writer;
   import vdp_pkg::*;

   localparam int         LP = 640;
   localparam logic [8:0] BG = 9'h0AB;

   logic        clk_draw = 1'b0;
   logic        rst_draw_n = 1'b0;
   logic        span_valid = 1'b0;
   logic        span_ready;
   logic [11:0] span_x = 12'd0;
   logic [12:0] span_len = 13'd0;
   logic [8:0]  span_colour = 9'd0;
   logic [8:0]  addr_off_draw;
   logic [7:0]  we_off_draw;
   logic [71:0] colour_off_draw;
   logic        clear_start = 1'b0;
   logic [8:0]  addr_on_draw;
   logic        we_on_draw;
   logic [71:0] colour_on_draw;
   logic        busy;
   logic        clear_busy;

   typedef struct {
      logic [8:0]  addr;
      logic [7:0]  we;
      logic [71:0] col;
      int          cy;
   } wr_t;

   wr_t sb[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;

   span_writer #(.LINE_PIXELS(LP), .BG_COLOUR(BG)) dut (
      .clk_draw(clk_draw), .rst_draw_n(rst_draw_n),
      .span_valid(span_valid), .span_ready(span_ready),
      .span_x(span_x), .span_len(span_len), .span_colour(span_colour),
      .addr_off_draw(addr_off_draw), .we_off_draw(we_off_draw), .colour_off_draw(colour_off_draw),
      .clear_start(clear_start), .addr_on_draw(addr_on_draw), .we_on_draw(we_on_draw),
      .colour_on_draw(colour_on_draw), .busy(busy), .clear_busy(clear_busy)
   );

   always #5 clk_draw = ~clk_draw;
   always @(posedge clk_draw) cyc <= cyc + 1;

   // Offer a span until accepted (bounded), then queue the words it should produce.
   task automatic send_span(input int x, input int len, input logic [8:0] col,
                            output int waits, output int acc);
      logic rdy;
      int   e;
      wr_t  t;
      span_x = 12'(x); span_len = 13'(len); span_colour = col; span_valid = 1'b1;
      waits = 0; rdy = 1'b0; acc = -1;
      while (!rdy && waits < 100) begin
         @(negedge clk_draw); rdy = span_ready;
         @(posedge clk_draw); #1;
         if (!rdy) waits++;
      end
      span_valid = 1'b0;
      if (!rdy) begin
         n_checks++; n_fail++;
         $display("FAIL accept_timeout x=%0d len=%0d not accepted, required acceptance within 100 cycles", x, len);
      end else begin
         acc = cyc - 1;
         e = x + len;
         if (e > LP) e = LP;
         if (e > x) begin
            for (int w = x / 8; w <= (e - 1) / 8; w++) begin
               t.addr = 9'(w); t.we = 8'h00; t.col = {8{col}}; t.cy = cyc + (w - x / 8);
               for (int i = 0; i < 8; i++) begin
                  if (w * 8 + i >= x && w * 8 + i < e) t.we[i] = 1'b1;
               end
               sb.push_back(t);
            end
         end
      end
   endtask

   // Pop and compare every off-screen write seen during n cycles.
   task automatic watch(input int n);
      wr_t e;
      for (int c = 0; c < n; c++) begin
         @(negedge clk_draw);
         if (rst_draw_n === 1'b1 && we_off_draw !== 8'h00) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write addr=%0d we=%h cyc=%0d, required no write", addr_off_draw, we_off_draw, cyc);
            end else begin
               e = sb.pop_front();
               if (addr_off_draw !== e.addr || we_off_draw !== e.we || colour_off_draw !== e.col ||
                   cyc != e.cy || busy !== 1'b1) begin
                  n_fail++;
                  $display("FAIL span_write got addr=%0d we=%h col=%h cyc=%0d busy=%b, required addr=%0d we=%h col=%h cyc=%0d busy=1",
                           addr_off_draw, we_off_draw, colour_off_draw, cyc, busy, e.addr, e.we, e.col, e.cy);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (we_off_draw !== 8'h00 || addr_off_draw !== 9'd0 || colour_off_draw !== 72'd0 || busy !== 1'b0 ||
          we_on_draw !== 1'b0 || addr_on_draw !== 9'd0 || clear_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got we=%h addr=%0d busy=%b we_on=%b addr_on=%0d clear_busy=%b, required all 0",
                  we_off_draw, addr_off_draw, busy, we_on_draw, addr_on_draw, clear_busy);
      end
      n_checks++;
      if (colour_on_draw !== {8{BG}}) begin
         n_fail++; $display("FAIL reset_colour_on got %h, required %h", colour_on_draw, {8{BG}});
      end
      repeat (2) @(posedge clk_draw);
      #1 rst_draw_n = 1'b1;
      @(negedge clk_draw);
      n_checks++;
      if (span_ready !== 1'b1 || busy !== 1'b0 || we_off_draw !== 8'h00) begin
         n_fail++; $display("FAIL reset_release got ready=%b busy=%b we=%h, required 1 0 00", span_ready, busy, we_off_draw);
      end
      @(posedge clk_draw); #1;
   endtask

   task automatic test_single();
      int w, a;
      fork
         send_span(3, 2, 9'h1A5, w, a);
         watch(6);
      join
      n_checks++;
      if (w != 0) begin n_fail++; $display("FAIL single_ready got %0d wait cycles, required 0", w); end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL single_drain got %0d pending, required 0", sb.size()); end
      sb.delete();
      @(posedge clk_draw); #1;
   endtask

   task automatic test_multi();
      int w, a;
      fork
         send_span(6, 12, 9'h055, w, a);
         watch(8);
      join
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL multi_drain got %0d pending, required 0", sb.size()); end
      sb.delete();
      @(posedge clk_draw); #1;
   endtask

   task automatic test_clip();
      int w1, a1, w2, a2;
      fork
         begin
            send_span(636, 10, 9'h1FF, w1, a1);
            send_span(700, 5, 9'h077, w2, a2);
            @(negedge clk_draw);
            n_checks++;
            if (w2 != 0 || span_ready !== 1'b1 || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL clip_no_stall got waits=%0d ready=%b busy=%b, required 0 1 0", w2, span_ready, busy);
            end
         end
         watch(10);
      join
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL clip_drain got %0d pending, required 0", sb.size()); end
      sb.delete();
      @(posedge clk_draw); #1;
   endtask

   task automatic test_back_to_back();
      int w, a1, a2, a3, a4, a5;
      fork
         begin
            send_span(0, 8, 9'h011, w, a1);
            send_span(8, 8, 9'h022, w, a2);
            send_span(16, 8, 9'h033, w, a3);
            send_span(100, 0, 9'h044, w, a4);
            send_span(24, 8, 9'h055, w, a5);
         end
         watch(14);
      join
      n_checks++;
      if (a2 != a1 + 1) begin n_fail++; $display("FAIL b2b_accept got cycle %0d, required %0d", a2, a1 + 1); end
      n_checks++;
      if (a4 != a3 + 1 || a5 != a4 + 1) begin
         n_fail++; $display("FAIL b2b_zero_len got cycles %0d %0d, required %0d %0d", a4, a5, a3 + 1, a3 + 2);
      end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain got %0d pending, required 0", sb.size()); end
      sb.delete();
      @(posedge clk_draw); #1;
   endtask

   task automatic test_clear();
      int w, a, n_wr, exp_addr;
      logic exp_we;
      n_wr = 0;
      fork
         begin
            clear_start = 1'b1;
            for (int c = 1; c <= 125; c++) begin
               @(posedge clk_draw); #1;
               clear_start = (c == 40);
               @(negedge clk_draw);
               exp_we   = (c <= 120);
               exp_addr = (c <= 40) ? c - 1 : c - 41;
               n_checks++;
               if (we_on_draw !== exp_we || clear_busy !== exp_we || (exp_we && addr_on_draw !== 9'(exp_addr))) begin
                  n_fail++;
                  $display("FAIL clear_step c=%0d got we=%b busy=%b addr=%0d, required we=%b addr=%0d",
                           c, we_on_draw, clear_busy, addr_on_draw, exp_we, exp_addr);
               end
               if (we_on_draw === 1'b1) n_wr++;
            end
         end
         send_span(0, 200, 9'h123, w, a);
         watch(130);
      join
      n_checks++;
      if (n_wr != 120) begin n_fail++; $display("FAIL clear_count got %0d writes, required 120", n_wr); end
      n_checks++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL clear_span_drain got %0d pending, required 0", sb.size()); end
      sb.delete();
      @(posedge clk_draw); #1;
   endtask

   task automatic test_reset_mid();
      int w, a;
      send_span(0, 40, 9'h0F0, w, a);
      watch(1);
      @(posedge clk_draw); #2;
      rst_draw_n = 1'b0;
      #1;
      n_checks++;
      if (we_off_draw !== 8'h00 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_immediate got we=%h busy=%b, required 00 0", we_off_draw, busy);
      end
      sb.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_draw);
         n_checks++;
         if (we_off_draw !== 8'h00) begin n_fail++; $display("FAIL reset_mid_hold got we=%h, required 00", we_off_draw); end
      end
      @(posedge clk_draw); #1;
      rst_draw_n = 1'b1;
      @(negedge clk_draw);
      n_checks++;
      if (span_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_release got ready=%b busy=%b, required 1 0", span_ready, busy);
      end
      watch(10);
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_clip();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
